// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and priority helpers for the PIC acknowledge core
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam int LVL_W  = 3;
    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } ack_state_t;

    typedef struct packed {
        logic             valid;
        logic             specific;
        logic [LVL_W-1:0] level;
    } eoi_cmd_t;

    typedef struct packed {
        logic             valid;
        logic [LVL_W-1:0] level;
    } prio_t;

    // Lowest index wins: IR0 is the highest priority.
    function automatic prio_t prio_encode(input logic [NUM_IR-1:0] bits);
        prio_t r;
        r.valid = 1'b0;
        r.level = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (bits[i]) begin
                r.valid = 1'b1;
                r.level = LVL_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_IR-1:0] level_mask(input logic [LVL_W-1:0] lvl);
        return NUM_IR'(1) << lvl;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// rtl/pic_priority_resolver.sv - fully-nested priority compare of unmasked IRR against ISR
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr,
    input  logic [NUM_IR-1:0] isr,
    output logic [LVL_W-1:0]  req_level,
    output logic              isr_valid,
    output logic [LVL_W-1:0]  isr_level,
    output logic              int_req
);

    prio_t req_p;
    prio_t isr_p;

    always_comb begin
        req_p = prio_encode(irr & ~imr);
        isr_p = prio_encode(isr);
    end

    assign req_level = req_p.level;
    assign isr_valid = isr_p.valid;
    assign isr_level = isr_p.level;
    assign int_req   = req_p.valid && (!isr_p.valid || (req_p.level < isr_p.level));

endmodule

// File: rtl/pic_ack_core.sv
// rtl/pic_ack_core.sv - IRR/ISR, priority, INT and two-pulse INTA vector sequencing (8086 mode)
module pic_ack_core #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_IR      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] ir_in,
    input  logic              inta_n,
    input  logic              icw1_write,
    input  logic              ltim,
    input  logic              aeoi,
    input  logic [4:0]        vector_base,
    input  logic [NUM_IR-1:0] imr,
    input  logic              eoi_valid,
    input  logic              eoi_specific,
    input  logic [2:0]        eoi_level,
    output logic              int_out,
    output logic [7:0]        vector_data,
    output logic              vector_oe,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr
);

    import pic_pkg::*;

    logic [SYNC_STAGES-1:0][NUM_IR-1:0] ir_sync;
    logic [SYNC_STAGES-1:0]             inta_sync;
    logic [NUM_IR-1:0] ir_lvl, ir_prev, ir_rise;
    logic inta_s, inta_prev, inta_fall, inta_rise;

    ack_state_t state, state_next;
    logic take_ack, load_vector, end_ack;
    logic int_next, oe_next;

    logic [LVL_W-1:0]  ack_level;
    logic              spurious;
    logic [NUM_IR-1:0] set_mask, clr_mask, isr_next, irr_next;

    logic [LVL_W-1:0] req_level, isr_level;
    logic             isr_valid, int_req;
    eoi_cmd_t         eoi;

    assign eoi = {eoi_valid, eoi_specific, eoi_level};

    // The INTA chain idles high so that leaving reset never looks like an acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_sync   <= '0;
            ir_prev   <= '0;
            inta_sync <= '1;
            inta_prev <= 1'b1;
        end else if (icw1_write) begin
            ir_sync   <= '0;
            ir_prev   <= '0;
            inta_sync <= '1;
            inta_prev <= 1'b1;
        end else begin
            ir_sync   <= {ir_sync[SYNC_STAGES-2:0], ir_in};
            ir_prev   <= ir_sync[SYNC_STAGES-1];
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
            inta_prev <= inta_sync[SYNC_STAGES-1];
        end
    end

    assign ir_lvl    = ir_sync[SYNC_STAGES-1];
    assign ir_rise   = ir_lvl & ~ir_prev;
    assign inta_s    = inta_sync[SYNC_STAGES-1];
    assign inta_fall = inta_prev & ~inta_s;
    assign inta_rise = ~inta_prev & inta_s;

    pic_priority_resolver u_resolver (
        .irr       (irr),
        .imr       (imr),
        .isr       (isr),
        .req_level (req_level),
        .isr_valid (isr_valid),
        .isr_level (isr_level),
        .int_req   (int_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (icw1_write) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        take_ack    = 1'b0;
        load_vector = 1'b0;
        end_ack     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inta_fall) begin
                    state_next = ST_ACK1;
                    take_ack   = 1'b1;
                end
            end
            ST_ACK1: begin
                if (inta_rise) state_next = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (inta_fall) begin
                    state_next  = ST_ACK2;
                    load_vector = 1'b1;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    state_next = ST_IDLE;
                    end_ack    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // INT stays low for the whole acknowledge; it is re-evaluated once back in IDLE.
        int_next = (state == ST_IDLE) && !take_ack && int_req;
        oe_next  = (state_next == ST_ACK2);
    end

    // An ISR set in the same cycle as an EOI clear of that bit wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (take_ack && int_req) set_mask = level_mask(req_level);
        if (eoi.valid) begin
            if (eoi.specific)   clr_mask = level_mask(eoi.level);
            else if (isr_valid) clr_mask = level_mask(isr_level);
        end
        if (end_ack && aeoi && !spurious) clr_mask = clr_mask | level_mask(ack_level);
        isr_next = (isr & ~clr_mask) | set_mask;
        if (ltim) irr_next = ir_lvl;
        else      irr_next = ((irr | ir_rise) & ir_lvl) & ~set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr         <= '0;
            isr         <= '0;
            int_out     <= 1'b0;
            vector_oe   <= 1'b0;
            vector_data <= '0;
            ack_level   <= '0;
            spurious    <= 1'b0;
        end else if (icw1_write) begin
            irr         <= '0;
            isr         <= '0;
            int_out     <= 1'b0;
            vector_oe   <= 1'b0;
            vector_data <= '0;
            ack_level   <= '0;
            spurious    <= 1'b0;
        end else begin
            irr       <= irr_next;
            isr       <= isr_next;
            int_out   <= int_next;
            vector_oe <= oe_next;
            if (take_ack) begin
                ack_level <= int_req ? req_level : SPURIOUS_LVL;
                spurious  <= !int_req;
            end
            if (load_vector) vector_data <= {vector_base, ack_level};
        end
    end

endmodule

// File: tb/tb_pic_ack_core.sv
// tb/tb_pic_ack_core.sv - directed table and sequence bench for pic_ack_core
module tb_pic_ack_core;
    import pic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] ir_in = '0;
    logic       inta_n = 1'b1;
    logic       icw1_write = 1'b0;
    logic       ltim = 1'b0;
    logic       aeoi = 1'b0;
    logic [4:0] vector_base = 5'b10101;
    logic [7:0] imr = '0;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       int_out;
    logic [7:0] vector_data;
    logic       vector_oe;
    logic [7:0] irr;
    logic [7:0] isr;

    int errors = 0;
    int checks = 0;

    pic_ack_core #(.SYNC_STAGES(2), .NUM_IR(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_in        (ir_in),
        .inta_n       (inta_n),
        .icw1_write   (icw1_write),
        .ltim         (ltim),
        .aeoi         (aeoi),
        .vector_base  (vector_base),
        .imr          (imr),
        .eoi_valid    (eoi_valid),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .int_out      (int_out),
        .vector_data  (vector_data),
        .vector_oe    (vector_oe),
        .irr          (irr),
        .isr          (isr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       ltim;
        logic [7:0] imr;
        logic [7:0] ir;
        logic [7:0] exp_irr;
        logic       exp_int;
        logic [7:0] exp_vec;
        logic [7:0] exp_isr;
        logic [7:0] exp_irr_after;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_core();
        ir_in = '0;
        imr = '0;
        icw1_write = 1'b1;
        tick(1);
        icw1_write = 1'b0;
        tick(1);
    endtask

    task automatic inta_pair(output logic [7:0] vec, output logic [7:0] isr_mid,
                             output logic int_mid, output logic oe1, output logic oe2);
        inta_n = 1'b0;
        tick(4);
        oe1 = vector_oe;
        isr_mid = isr;
        int_mid = int_out;
        inta_n = 1'b1;
        tick(4);
        inta_n = 1'b0;
        tick(4);
        oe2 = vector_oe;
        vec = vector_data;
        inta_n = 1'b1;
        tick(4);
    endtask

    task automatic eoi_cmd(input logic specific, input logic [2:0] lvl);
        eoi_valid = 1'b1;
        eoi_specific = specific;
        eoi_level = lvl;
        tick(1);
        eoi_valid = 1'b0;
        tick(1);
    endtask

    logic [7:0] v, im;
    logic       ii, o1, o2;

    initial begin
        tbl[0] = '{1'b0, 8'h00, 8'h01, 8'h01, 1'b1, 8'hA8, 8'h01, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 8'hC0, 8'hC0, 1'b1, 8'hAE, 8'h40, 8'h80};
        tbl[2] = '{1'b0, 8'h0F, 8'hFF, 8'hFF, 1'b1, 8'hAC, 8'h10, 8'hEF};
        tbl[3] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hAF, 8'h00, 8'hFF};
        tbl[4] = '{1'b0, 8'h04, 8'h24, 8'h24, 1'b1, 8'hAD, 8'h20, 8'h04};
        tbl[5] = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b1, 8'hAF, 8'h80, 8'h80};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'hAF, 8'h00, 8'h00};

        #2 rst_n = 1'b0;
        tick(2);
        check("reset_int", {7'd0, int_out}, 8'h00);
        check("reset_oe", {7'd0, vector_oe}, 8'h00);
        check("reset_vec", vector_data, 8'h00);
        check("reset_irr", irr, 8'h00);
        check("reset_isr", isr, 8'h00);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            clear_core();
            ltim = tbl[i].ltim;
            imr = tbl[i].imr;
            ir_in = tbl[i].ir;
            tick(5);
            check($sformatf("t%0d_irr", i), irr, tbl[i].exp_irr);
            check($sformatf("t%0d_int", i), {7'd0, int_out}, {7'd0, tbl[i].exp_int});
            inta_pair(v, im, ii, o1, o2);
            check($sformatf("t%0d_oe1", i), {7'd0, o1}, 8'h00);
            check($sformatf("t%0d_int_ack", i), {7'd0, ii}, 8'h00);
            check($sformatf("t%0d_isr_mid", i), im, tbl[i].exp_isr);
            check($sformatf("t%0d_oe2", i), {7'd0, o2}, 8'h01);
            check($sformatf("t%0d_vec", i), v, tbl[i].exp_vec);
            check($sformatf("t%0d_oe_end", i), {7'd0, vector_oe}, 8'h00);
            check($sformatf("t%0d_isr_end", i), isr, tbl[i].exp_isr);
            check($sformatf("t%0d_irr_end", i), irr, tbl[i].exp_irr_after);
        end
        ltim = 1'b0;

        // Latency and specific EOI on IR0.
        clear_core();
        ir_in = 8'h01;
        tick(3);
        check("lat_irr3", irr, 8'h01);
        check("lat_int3", {7'd0, int_out}, 8'h00);
        tick(1);
        check("lat_int4", {7'd0, int_out}, 8'h01);
        inta_pair(v, im, ii, o1, o2);
        check("lat_vec", v, 8'hA8);
        check("lat_isr", isr, 8'h01);
        eoi_cmd(1'b1, 3'd0);
        check("lat_eoi_isr", isr, 8'h00);

        // Automatic EOI.
        clear_core();
        aeoi = 1'b1;
        vector_base = 5'b11101;
        ir_in = 8'h01;
        tick(5);
        inta_pair(v, im, ii, o1, o2);
        check("aeoi_isr_mid", im, 8'h01);
        check("aeoi_vec", v, 8'hE8);
        check("aeoi_isr_end", isr, 8'h00);
        aeoi = 1'b0;
        vector_base = 5'b10101;

        // Nesting around IR4.
        clear_core();
        ir_in = 8'h10;
        tick(5);
        inta_pair(v, im, ii, o1, o2);
        check("nest_vec4", v, 8'hAC);
        check("nest_isr4", isr, 8'h10);
        ir_in = 8'h00;
        tick(4);
        ir_in = 8'h20;
        tick(5);
        check("nest_int_ir5", {7'd0, int_out}, 8'h00);
        ir_in = 8'h30;
        tick(5);
        check("nest_int_ir4", {7'd0, int_out}, 8'h00);
        check("nest_irr", irr, 8'h30);
        ir_in = 8'h38;
        tick(5);
        check("nest_int_ir3", {7'd0, int_out}, 8'h01);
        inta_pair(v, im, ii, o1, o2);
        check("nest_vec3", v, 8'hAB);
        check("nest_isr18", isr, 8'h18);
        tick(2);
        check("nest_int_after3", {7'd0, int_out}, 8'h00);
        eoi_cmd(1'b1, 3'd3);
        check("nest_eoi3_isr", isr, 8'h10);
        check("nest_eoi3_int", {7'd0, int_out}, 8'h00);
        eoi_cmd(1'b1, 3'd4);
        check("nest_eoi4_isr", isr, 8'h00);
        check("nest_eoi4_int", {7'd0, int_out}, 8'h01);
        inta_pair(v, im, ii, o1, o2);
        check("nest_vec4b", v, 8'hAC);
        check("nest_irr20", irr, 8'h20);
        eoi_cmd(1'b0, 3'd0);
        check("nest_nseoi_isr", isr, 8'h00);
        check("nest_int_ir5b", {7'd0, int_out}, 8'h01);
        inta_pair(v, im, ii, o1, o2);
        check("nest_vec5", v, 8'hAD);
        eoi_cmd(1'b0, 3'd0);
        check("nest_final_isr", isr, 8'h00);

        // Level-mode request withdrawn before INTA.
        clear_core();
        ltim = 1'b1;
        ir_in = 8'h04;
        tick(5);
        check("lvl_irr", irr, 8'h04);
        check("lvl_int", {7'd0, int_out}, 8'h01);
        ir_in = 8'h00;
        tick(5);
        check("lvl_irr_drop", irr, 8'h00);
        inta_pair(v, im, ii, o1, o2);
        check("lvl_spur_vec", v, 8'hAF);
        check("lvl_spur_isr", isr, 8'h00);
        ltim = 1'b0;

        // Full mask, then unmask IR6.
        clear_core();
        imr = 8'hFF;
        ir_in = 8'hFF;
        tick(5);
        check("mask_irr", irr, 8'hFF);
        check("mask_int", {7'd0, int_out}, 8'h00);
        imr = 8'hBF;
        tick(1);
        check("unmask_int", {7'd0, int_out}, 8'h01);

        // Async reset while in WAIT2.
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
        tick(4);
        check("wait2_isr", isr, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        check("rst_int", {7'd0, int_out}, 8'h00);
        check("rst_oe", {7'd0, vector_oe}, 8'h00);
        check("rst_vec", vector_data, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_irr", irr, 8'h00);
        check("rst_fsm", 8'(dut.state), 8'(ST_IDLE));
        tick(1);
        rst_n = 1'b1;
        ir_in = 8'h00;
        imr = 8'h00;
        tick(2);

        // ICW1 re-initialise during ACK2.
        ir_in = 8'h02;
        tick(5);
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
        tick(4);
        inta_n = 1'b0;
        tick(4);
        check("icw1_pre_oe", {7'd0, vector_oe}, 8'h01);
        check("icw1_pre_vec", vector_data, 8'hA9);
        icw1_write = 1'b1;
        tick(1);
        icw1_write = 1'b0;
        inta_n = 1'b1;
        check("icw1_oe", {7'd0, vector_oe}, 8'h00);
        check("icw1_isr", isr, 8'h00);
        check("icw1_irr", irr, 8'h00);
        check("icw1_fsm", 8'(dut.state), 8'(ST_IDLE));
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
